// File: rtl/mesh_feed_pkg.sv
// Shared encodings for the mesh edge feeder: control FSM states and the
// mode / edge selector values latched at stream start.
package mesh_feed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } feed_state_e;

    localparam logic MODE_SYSTOLIC = 1'b0;
    localparam logic MODE_DIRECT   = 1'b1;

    localparam logic DIR_NORTH = 1'b0;
    localparam logic DIR_WEST  = 1'b1;

endpackage

// File: rtl/mesh_edge_feeder_if.sv
// Load, control, configuration and edge-output bundle of the mesh edge feeder.
// master = the loader / controller side, slave = the feeder itself.
interface mesh_edge_feeder_if #(
    parameter int DW    = 32,
    parameter int LANES = 4,
    parameter int CFG_W = 64
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [LW-1:0]         wr_lane;
    logic [DW-1:0]         wr_data;
    logic                  start;
    logic                  mode;
    logic                  dir;
    logic                  cfg_valid;
    logic [CFG_W-1:0]      cfg_in;
    logic [CFG_W-1:0]      cfg_out;
    logic                  busy;
    logic                  done;
    logic [LANES-1:0]      west_valid;
    logic [LANES*DW-1:0]   west_data;
    logic [LANES-1:0]      north_valid;
    logic [LANES*DW-1:0]   north_data;

    modport master (
        output wr_valid, wr_lane, wr_data, start, mode, dir, cfg_valid, cfg_in,
        input  wr_ready, cfg_out, busy, done, west_valid, west_data, north_valid, north_data
    );

    modport slave (
        input  wr_valid, wr_lane, wr_data, start, mode, dir, cfg_valid, cfg_in,
        output wr_ready, cfg_out, busy, done, west_valid, west_data, north_valid, north_data
    );

endinterface

// File: rtl/feeder_lane_fifo.sv
// Per-lane word buffer: DEPTH entries (power of two), wrapping pointers,
// fill counter one bit wider than the pointers. Head word is shown
// combinationally; pushes to a full buffer and pops of an empty one are ignored.
module feeder_lane_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    // Qualify requests against the fill level, then advance pointers and count.
    always_comb begin
        do_push_s = push && (cnt_q != CW'(DEPTH));
        do_pop_s  = pop && (cnt_q != '0);
        if (do_push_s) wptr_d = wptr_q + AW'(1);
        else           wptr_d = wptr_q;
        if (do_pop_s)  rptr_d = rptr_q + AW'(1);
        else           rptr_d = rptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and fill-level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array, cleared on reset so stale words can never resurface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else if (do_push_s) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/mesh_edge_feeder.sv
// Edge-injection block for the systolic mesh: buffers words per lane while
// idle, then streams them onto the west edge (skewed or direct) or the north
// edge (direct). Popped words pass one capture stage and one output register,
// so lane 0 data appears two edges after start is sampled. Also registers the
// configuration word forwarded to the mesh.
module mesh_edge_feeder #(
    parameter int DW        = 32,
    parameter int LANES     = 4,
    parameter int DEPTH     = 4,
    parameter int SKEW_STEP = 1,
    parameter int CFG_W     = 64
) (
    input  logic              clk,
    input  logic              reset,
    mesh_edge_feeder_if.slave bus
);
    import mesh_feed_pkg::*;

    localparam int TW = $clog2((LANES - 1) * SKEW_STEP + DEPTH + 1);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [TW-1:0] T_MAX = {TW{1'b1}};

    feed_state_e         state_q, state_d;
    logic [TW-1:0]       t_q, t_d;
    logic                mode_q, mode_d, dir_q, dir_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [LANES-1:0]    s1_valid_q, s1_valid_d;
    logic [LANES*DW-1:0] s1_data_q, s1_data_d;
    logic [LANES-1:0]    west_valid_q, west_valid_d, north_valid_q, north_valid_d;
    logic [LANES*DW-1:0] west_data_q, west_data_d, north_data_q, north_data_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;

    logic [LANES-1:0]    push_s, pop_s, full_s, empty_s;
    logic [DW-1:0]       head_s  [LANES];
    logic [CW-1:0]       count_s [LANES];
    logic                wr_ready_s, drained_s, west_sel_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        feeder_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (reset),
            .push      (push_s[g]),
            .push_data (bus.wr_data),
            .pop       (pop_s[g]),
            .head      (head_s[g]),
            .count     (count_s[g]),
            .full      (full_s[g]),
            .empty     (empty_s[g])
        );
    end

    // Write acceptance: only while idle, only to an existing lane with room.
    always_comb begin
        wr_ready_s = 1'b0;
        push_s     = '0;
        if (reset && (state_q == IDLE) && (32'(bus.wr_lane) < 32'(LANES))) begin
            wr_ready_s = !full_s[bus.wr_lane];
        end else begin
            wr_ready_s = 1'b0;
        end
        for (int i = 0; i < LANES; i++) begin
            push_s[i] = bus.wr_valid && wr_ready_s && (32'(bus.wr_lane) == 32'(i));
        end
    end

    // Pop scheduling: direct mode fires every lane from t=0, systolic mode
    // releases lane i once t reaches its skew; drained marks the final pop.
    always_comb begin
        pop_s     = '0;
        drained_s = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if ((state_q == RUN) && !empty_s[i]) begin
                pop_s[i] = (mode_q == MODE_DIRECT) || (32'(t_q) >= 32'(i * SKEW_STEP));
            end else begin
                pop_s[i] = 1'b0;
            end
            if (!empty_s[i] && !(pop_s[i] && (count_s[i] == CW'(1)))) drained_s = 1'b0;
            else                                                      drained_s = drained_s;
        end
    end

    // Control FSM next state, capture stage, edge routing and config capture.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    t_d     = '0;
                    mode_d  = bus.mode;
                    dir_d   = bus.dir;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (t_q == T_MAX) t_d = t_q;
                else              t_d = t_q + TW'(1);
                if (drained_s) state_d = FIN;
                else           state_d = RUN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_q == FIN);

        west_sel_s    = (mode_q == MODE_SYSTOLIC) || (dir_q == DIR_WEST);
        s1_valid_d    = pop_s;
        s1_data_d     = '0;
        west_valid_d  = '0;
        west_data_d   = '0;
        north_valid_d = '0;
        north_data_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pop_s[i]) s1_data_d[i*DW +: DW] = head_s[i];
            else          s1_data_d[i*DW +: DW] = '0;
            if (s1_valid_q[i] && west_sel_s) begin
                west_valid_d[i]          = 1'b1;
                west_data_d[i*DW +: DW]  = s1_data_q[i*DW +: DW];
            end else begin
                west_valid_d[i]          = 1'b0;
                west_data_d[i*DW +: DW]  = '0;
            end
            if (s1_valid_q[i] && !west_sel_s) begin
                north_valid_d[i]         = 1'b1;
                north_data_d[i*DW +: DW] = s1_data_q[i*DW +: DW];
            end else begin
                north_valid_d[i]         = 1'b0;
                north_data_d[i*DW +: DW] = '0;
            end
        end

        if (bus.cfg_valid) cfg_d = bus.cfg_in;
        else               cfg_d = cfg_q;
    end

    // All state and registered outputs; reset aborts any stream without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            t_q           <= '0;
            mode_q        <= MODE_SYSTOLIC;
            dir_q         <= DIR_NORTH;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            s1_valid_q    <= '0;
            s1_data_q     <= '0;
            west_valid_q  <= '0;
            west_data_q   <= '0;
            north_valid_q <= '0;
            north_data_q  <= '0;
            cfg_q         <= '0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            mode_q        <= mode_d;
            dir_q         <= dir_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            west_valid_q  <= west_valid_d;
            west_data_q   <= west_data_d;
            north_valid_q <= north_valid_d;
            north_data_q  <= north_data_d;
            cfg_q         <= cfg_d;
        end
    end

    assign bus.wr_ready    = wr_ready_s;
    assign bus.cfg_out     = cfg_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.west_valid  = west_valid_q;
    assign bus.west_data   = west_data_q;
    assign bus.north_valid = north_valid_q;
    assign bus.north_data  = north_data_q;

endmodule

// File: tb/tb_mesh_edge_feeder.sv
// Directed bench for mesh_edge_feeder (LANES=4, DEPTH=4, SKEW_STEP=1):
// a per-cycle vector table for the streaming scenarios, then hand-written
// sequences for empty start, reset during a stream and the config path.
module tb_mesh_edge_feeder;
    import mesh_feed_pkg::*;

    localparam int DW = 32, LANES = 4, DEPTH = 4, SKEW = 1, CFG_W = 64;
    localparam logic [63:0] CFG_WORD = 64'hDEADBEEF_01234567;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mesh_edge_feeder_if #(.DW(DW), .LANES(LANES), .CFG_W(CFG_W)) bus ();

    mesh_edge_feeder #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH), .SKEW_STEP(SKEW), .CFG_W(CFG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic         wr_valid;
        logic [1:0]   wr_lane;
        logic [31:0]  wr_data;
        logic         start;
        logic         mode;
        logic         dir;
        logic         x_rdy;
        logic [3:0]   x_wv;
        logic [127:0] x_wd;
        logic [3:0]   x_nv;
        logic [127:0] x_nd;
        logic         x_busy;
        logic         x_done;
    } vec_t;

    vec_t vecs[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int idx, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s #%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic wv, input logic [1:0] wl, input logic [31:0] wd,
                       input logic st, input logic md, input logic dr, input logic rdy,
                       input logic [3:0] ewv, input logic [127:0] ewd,
                       input logic [3:0] env, input logic [127:0] end_data,
                       input logic eb, input logic ed);
        vec_t v;
        v.wr_valid = wv;  v.wr_lane = wl;  v.wr_data = wd;
        v.start = st;     v.mode = md;     v.dir = dr;     v.x_rdy = rdy;
        v.x_wv = ewv;     v.x_wd = ewd;    v.x_nv = env;   v.x_nd = end_data;
        v.x_busy = eb;    v.x_done = ed;
        vecs.push_back(v);
    endtask

    // Write vector: outputs expected quiet while loading.
    task automatic wr(input int lane, input int data, input logic rdy);
        add(1'b1, 2'(lane), 32'(data), 1'b0, 1'b0, 1'b0, rdy, 4'b0, 128'b0, 4'b0, 128'b0, 1'b0, 1'b0);
    endtask

    // Idle-input vector with expected outputs.
    task automatic step(input logic rdy, input logic [3:0] ewv, input logic [127:0] ewd,
                        input logic [3:0] env, input logic [127:0] end_data,
                        input logic eb, input logic ed);
        add(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, rdy, ewv, ewd, env, end_data, eb, ed);
    endtask

    function automatic logic [127:0] p4(input int l3, input int l2, input int l1, input int l0);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    task automatic do_wr(input int lane, input int data);
        bus.wr_valid = 1'b1;
        bus.wr_lane  = 2'(lane);
        bus.wr_data  = 32'(data);
        tick;
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_cnt, vld_cnt, done_first, seen_k, done_k;
        logic [3:0]   seen_wv;
        logic [127:0] seen_wd;

        reset = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_lane = 2'd0; bus.wr_data = 32'd0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_in = 64'd0;

        // Reset state
        #2;
        chk("rst_west",  0, 256'({bus.west_valid, bus.west_data}), 256'd0);
        chk("rst_north", 0, 256'({bus.north_valid, bus.north_data}), 256'd0);
        chk("rst_busy_done", 0, 256'({bus.busy, bus.done}), 256'd0);
        chk("rst_cfg", 0, 256'(bus.cfg_out), 256'd0);
        chk("rst_wr_ready", 0, 256'(bus.wr_ready), 256'd0);
        tick; tick;
        reset = 1'b1;
        #1;
        chk("post_rst_wr_ready", 0, 256'(bus.wr_ready), 256'd1);

        // ---- Systolic stream: lane i holds i*16+1 .. i*16+4 ----
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) wr(i, i * 16 + 1 + j, 1'b1);
        add(1'b0, 2'd0, 32'd0, 1'b1, MODE_SYSTOLIC, 1'b0, 1'b0, 4'b0, 128'b0, 4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, p4(0, 0, 0, 0),    4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0001, p4(0, 0, 0, 1),    4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0011, p4(0, 0, 17, 2),   4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0111, p4(0, 33, 18, 3),  4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b1111, p4(49, 34, 19, 4), 4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b1110, p4(50, 35, 20, 0), 4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b1100, p4(51, 36, 0, 0),  4'b0, 128'b0, 1'b0, 1'b0);
        step(1'b0, 4'b1000, p4(52, 0, 0, 0),   4'b0, 128'b0, 1'b0, 1'b1);
        step(1'b1, 4'b0000, p4(0, 0, 0, 0),    4'b0, 128'b0, 1'b0, 1'b0);

        // ---- Direct north, uneven fill ----
        wr(0, 'hA, 1'b1); wr(0, 'hB, 1'b1); wr(2, 'hC, 1'b1);
        add(1'b0, 2'd0, 32'd0, 1'b1, MODE_DIRECT, DIR_NORTH, 1'b1, 4'b0, 128'b0, 4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0, 128'b0, 4'b0000, p4(0, 0, 0, 0),     1'b1, 1'b0);
        step(1'b0, 4'b0, 128'b0, 4'b0101, p4(0, 'hC, 0, 'hA), 1'b0, 1'b0);
        step(1'b0, 4'b0, 128'b0, 4'b0001, p4(0, 0, 0, 'hB),   1'b0, 1'b1);
        step(1'b1, 4'b0, 128'b0, 4'b0000, p4(0, 0, 0, 0),     1'b0, 1'b0);

        // ---- Full lane, dropped 5th write, write accepted with start ----
        for (int j = 0; j < 4; j++) wr(1, 'h100 + j, 1'b1);
        wr(1, 'h104, 1'b0);
        add(1'b1, 2'd2, 32'h200, 1'b1, MODE_DIRECT, DIR_WEST, 1'b1, 4'b0, 128'b0, 4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, p4(0, 0, 0, 0),          4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0110, p4(0, 'h200, 'h100, 0),  4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0010, p4(0, 0, 'h101, 0),      4'b0, 128'b0, 1'b1, 1'b0);
        step(1'b0, 4'b0010, p4(0, 0, 'h102, 0),      4'b0, 128'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0010, p4(0, 0, 'h103, 0),      4'b0, 128'b0, 1'b0, 1'b1);
        step(1'b1, 4'b0000, p4(0, 0, 0, 0),          4'b0, 128'b0, 1'b0, 1'b0);

        foreach (vecs[n]) begin
            bus.wr_valid = vecs[n].wr_valid;
            bus.wr_lane  = vecs[n].wr_lane;
            bus.wr_data  = vecs[n].wr_data;
            bus.start    = vecs[n].start;
            bus.mode     = vecs[n].mode;
            bus.dir      = vecs[n].dir;
            #1;
            chk("wr_ready", n, 256'(bus.wr_ready), 256'(vecs[n].x_rdy));
            tick;
            chk("west", n, 256'({bus.west_valid, bus.west_data}), 256'({vecs[n].x_wv, vecs[n].x_wd}));
            chk("north", n, 256'({bus.north_valid, bus.north_data}), 256'({vecs[n].x_nv, vecs[n].x_nd}));
            chk("busy_done", n, 256'({bus.busy, bus.done}), 256'({vecs[n].x_busy, vecs[n].x_done}));
        end
        bus.wr_valid = 1'b0; bus.start = 1'b0; bus.wr_lane = 2'd0;

        // ---- Empty start ----
        bus.start = 1'b1; bus.mode = MODE_SYSTOLIC;
        tick;
        bus.start = 1'b0;
        done_cnt = 0; vld_cnt = 0; done_first = -1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            if (bus.done) begin
                done_cnt++;
                if (done_first < 0) done_first = k;
            end
            if ((bus.west_valid != 4'b0) || (bus.north_valid != 4'b0)) vld_cnt++;
        end
        chk("empty_done_count", 0, 256'(done_cnt), 256'd1);
        chk("empty_done_within_2", 0, 256'((done_first >= 1) && (done_first <= 2)), 256'd1);
        chk("empty_no_valid", 0, 256'(vld_cnt), 256'd0);
        chk("empty_back_idle", 0, 256'({bus.busy, bus.wr_ready}), 256'b01);

        // ---- Reset in the middle of a systolic stream ----
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++) do_wr(i, 'h300 + i * 16 + j);
        bus.wr_lane = 2'd0;
        bus.start = 1'b1; bus.mode = MODE_SYSTOLIC;
        tick;
        bus.start = 1'b0;
        tick; tick;
        chk("rr_pre_west", 0, 256'({bus.west_valid, bus.west_data}), 256'({4'b0001, p4(0, 0, 0, 'h300)}));
        reset = 1'b0;
        #1;
        chk("rr_west", 0, 256'({bus.west_valid, bus.west_data}), 256'd0);
        chk("rr_north", 0, 256'({bus.north_valid, bus.north_data}), 256'd0);
        chk("rr_busy_done", 0, 256'({bus.busy, bus.done}), 256'd0);
        done_cnt = 0; vld_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            tick;
            if (bus.done) done_cnt++;
        end
        reset = 1'b1;
        bus.wr_lane = 2'd3;
        #1;
        chk("rr_wr_ready", 0, 256'(bus.wr_ready), 256'd1);
        for (int k = 0; k < 6; k++) begin
            tick;
            if (bus.done) done_cnt++;
            if ((bus.west_valid != 4'b0) || (bus.north_valid != 4'b0)) vld_cnt++;
        end
        chk("rr_no_done", 0, 256'(done_cnt), 256'd0);
        chk("rr_no_valid", 0, 256'(vld_cnt), 256'd0);

        // ---- New stream after reset, with a config update during RUN ----
        do_wr(3, 'h3AA);
        bus.start = 1'b1; bus.mode = MODE_SYSTOLIC;
        tick;
        bus.start = 1'b0;
        seen_k = -1; done_k = -1; done_cnt = 0; vld_cnt = 0;
        seen_wv = 4'b0; seen_wd = 128'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) begin
                bus.cfg_valid = 1'b1; bus.cfg_in = CFG_WORD;
            end else begin
                bus.cfg_valid = 1'b0; bus.cfg_in = ~CFG_WORD;
            end
            tick;
            if (k == 1) chk("cfg_load", k, 256'(bus.cfg_out), 256'(CFG_WORD));
            if (k == 4) chk("cfg_hold", k, 256'(bus.cfg_out), 256'(CFG_WORD));
            if ((bus.west_valid != 4'b0) || (bus.north_valid != 4'b0)) begin
                vld_cnt++;
                if (seen_k < 0) begin
                    seen_k = k; seen_wv = bus.west_valid; seen_wd = bus.west_data;
                end
            end
            if (bus.done) begin
                done_cnt++; done_k = k;
            end
        end
        chk("new_lane3_cycle", 0, 256'(seen_k), 256'd5);
        chk("new_lane3_word", 0, 256'({seen_wv, seen_wd}), 256'({4'b1000, p4('h3AA, 0, 0, 0)}));
        chk("new_valid_count", 0, 256'(vld_cnt), 256'd1);
        chk("new_done_count", 0, 256'(done_cnt), 256'd1);
        chk("new_done_cycle", 0, 256'(done_k), 256'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
